// File: rtl/dmem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_arbiter : round-robin, burst-lockable arbiter sharing one data BRAM
// Rev 1.0
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_0,
  input  logic              we_0,
  input  logic              lock_0,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [DATA_W-1:0] wdata_0,
  output logic              gnt_0,
  output logic              rvalid_0,
  output logic [DATA_W-1:0] rdata_0,
  input  logic              req_1,
  input  logic              we_1,
  input  logic              lock_1,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] wdata_1,
  output logic              gnt_1,
  output logic              rvalid_1,
  output logic [DATA_W-1:0] rdata_1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  logic             last;
  logic             locked;
  logic [CNT_W-1:0] lock_cnt;
  logic             rd_pend;
  logic             rd_owner;

  logic sel;
  logic sel_lock;
  logic hold;
  logic any_req;

  always_comb begin
    hold = locked && (lock_cnt < CNT_W'(MAX_LOCK));
    if (req_0 && req_1) sel = hold ? last : ~last;
    else                sel = req_1;
    // Grants are suppressed while reset is held so the BRAM sees no access.
    any_req   = (req_0 | req_1) & reset;
    gnt_0     = any_req & ~sel;
    gnt_1     = any_req & sel;
    mem_en    = any_req;
    mem_we    = any_req & (sel ? we_1 : we_0);
    mem_addr  = sel ? addr_1[ADDR_W-1:2] : addr_0[ADDR_W-1:2];
    mem_wdata = sel ? wdata_1 : wdata_0;
    sel_lock  = sel ? lock_1 : lock_0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last     <= 1'b1;
      locked   <= 1'b0;
      lock_cnt <= '0;
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      rd_pend <= mem_en & ~mem_we;
      if (mem_en) begin
        last     <= sel;
        rd_owner <= sel;
        if (sel_lock) begin
          locked <= 1'b1;
          if (sel != last)                        lock_cnt <= CNT_W'(1);
          else if (lock_cnt < CNT_W'(MAX_LOCK))   lock_cnt <= lock_cnt + CNT_W'(1);
        end else begin
          locked   <= 1'b0;
          lock_cnt <= '0;
        end
      end else begin
        locked   <= 1'b0;
        lock_cnt <= '0;
      end
    end
  end

  assign rvalid_0 = rd_pend & ~rd_owner;
  assign rvalid_1 = rd_pend & rd_owner;
  assign rdata_0  = mem_rdata;
  assign rdata_1  = mem_rdata;

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port data-memory BRAM (word-addressed, 1-cycle read latency, `ena`/`wea` style) between the CPU data port and a second bus master (program loader / debug DMA). It sits between `Computer`'s data-memory port, the loader, and the `dataMem` instance in the top-level wrapper. It issues at most one memory access per cycle and uses round-robin priority, with a bounded lock for bursts. It returns read data to the owner of each read one cycle after that read is granted.

## Interface
Parameters:
- `ADDR_W`, 12: requester byte-address width; memory word address is `ADDR_W-2` bits.
- `DATA_W`, 32: data width.
- `MAX_LOCK`, 8: max consecutive locked grants to one port while the other port is requesting (≥1).

Ports (`i` = 0 CPU, 1 loader; each listed once per port):
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_i`  in  1  access request; hold with `we/addr/wdata/lock` stable until granted.
- `we_i`  in  1  1 = write, 0 = read.
- `lock_i`  in  1  request to keep the grant on the next cycle (burst).
- `addr_i`  in  ADDR_W  byte address; bits [1:0] ignored.
- `wdata_i`  in  DATA_W  write data.
- `gnt_i`  out  1  combinational; the access is issued this cycle.
- `rvalid_i`  out  1  registered; `rdata_i` holds this port's read result.
- `rdata_i`  out  DATA_W  equals `mem_rdata`; meaningful only when `rvalid_i`=1.
- `mem_en`  out  1  BRAM enable.
- `mem_we`  out  1  BRAM write enable.
- `mem_addr`  out  ADDR_W-2  word address = granted `addr[ADDR_W-1:2]`.
- `mem_wdata`  out  DATA_W  granted write data.
- `mem_rdata`  in  DATA_W  BRAM read data, valid the cycle after the read `mem_en`.

## Operation
- State registers: `last` (1 bit, last granted port), `locked` (1 bit), `lock_cnt` (counts to MAX_LOCK), `rd_owner`/`rd_pend` (read-return pipeline).
- Grant selection, all in the same cycle:
  - Only one port requesting: that port is granted.
  - Both requesting, `locked`=1 with owner = `last`, and `lock_cnt` < MAX_LOCK: `last` is granted.
  - Both requesting otherwise: `!last` is granted (round robin).
- On a grant to port g: `mem_en`=1, `mem_we`=`we_g`, and `mem_addr`/`mem_wdata` are muxed from port g. `last`←g.
- Lock handling on a grant to port g:
  - If `lock_g`=1: `locked`←1. `lock_cnt`←`lock_cnt`+1 when g equals the previous owner, otherwise 1.
  - If `lock_g`=0: `locked`←0 and `lock_cnt`←0.
  - No grant this cycle: `locked`←0 and `lock_cnt`←0.
  - `lock_cnt` saturates at MAX_LOCK.
- Lock limit: when the lock limit forces rotation, `lock_cnt` restarts at 1 if the newly granted port itself asserts lock.
- A lock does not block an idle other port. If the other port is not requesting, the owner may be granted indefinitely.
- Read return: on a read grant, `rd_pend`←1 and `rd_owner`←g. The next cycle, `rvalid_{rd_owner}`=1. Writes never produce `rvalid`.
- Back-to-back reads to alternating ports each return in order, one per cycle.

## Timing
- Reset (`reset`=0, async) sets `rvalid_0`=`rvalid_1`=0, `last`=1 (port 0 wins the first tie), `locked`=0, `lock_cnt`=0, `rd_pend`=0.
- While in reset, `gnt_*` and `mem_en` are forced to 0.
- Grant latency is 0 cycles: a request seen at edge N is issued to the BRAM at edge N if granted.
- Read latency: read granted in cycle N → `rvalid`/`rdata` valid in cycle N+1 for exactly one cycle.
- Throughput: 1 access per cycle total. Under continuous contention without lock, grants alternate 0,1,0,1…
- Same-address write in N then read in N+1: the read returns the new data in N+2 (BRAM write-first/no-conflict, since accesses are sequential).
- Reset asserted mid-read (between grant and return): the in-flight `rvalid` is dropped and never asserted.
- No requests: `mem_en`=0, `mem_we`=0, and state other than `locked`/`lock_cnt` clearing is unchanged.

## Test plan
- Single read: port 0 reads 0x010 once, BRAM word 4 = 0xDEADBEEF → `gnt_0`=1 and `mem_addr`=4 in cycle N; `rvalid_0`=1 and `rdata_0`=0xDEADBEEF in N+1; `rvalid_1` stays 0.
- First-tie priority: after reset, both ports request reads continuously → grants 0,1,0,1; each `rvalid_i` pulses the cycle after its own grant.
- Lock limit: port 1 requests 10 locked writes while port 0 requests continuously, MAX_LOCK=8 → port 1 gets 8 consecutive grants, then port 0 gets 1, then port 1 resumes.
- Write-then-read: port 1 writes 0x12345678 to 0x044, then port 0 reads 0x044 → `mem_we`=1 and `mem_addr`=0x11, then `rdata_0`=0x12345678 with `rvalid_0`=1.
- Reset mid-read: port 0 read granted in cycle N, `reset`=0 during N+1 → `rvalid_0`=0 in N+1 and after; after release, the first tie goes to port 0.
- Idle/unaligned: no requests → `mem_en`=0 for 20 cycles; then port 1 reads 0x013 → `mem_addr`=4.
